key_event: RTL and testbench



---
 rtl/key_pkg.sv | 46 ++++
 rtl/key_repeat_timer.sv | 75 +++++++
 rtl/key_event.sv | 150 +++++++++++++++
 tb/tb_key_event.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared definitions for the keypad path (scanner, key_event,
//                game FSM): key code width, "no key" code, the 16 key codes
//                and the key_event state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    // Key code: [3:0] = key number 0..15, [4] = 1 marks "invalid / no key".
    localparam int              KEY_W    = 5;
    localparam logic [KEY_W-1:0] KEY_NONE = 5'h10;

    localparam logic [KEY_W-1:0] KEY_0 = 5'h00;
    localparam logic [KEY_W-1:0] KEY_1 = 5'h01;
    localparam logic [KEY_W-1:0] KEY_2 = 5'h02;
    localparam logic [KEY_W-1:0] KEY_3 = 5'h03;
    localparam logic [KEY_W-1:0] KEY_4 = 5'h04;
    localparam logic [KEY_W-1:0] KEY_5 = 5'h05;
    localparam logic [KEY_W-1:0] KEY_6 = 5'h06;
    localparam logic [KEY_W-1:0] KEY_7 = 5'h07;
    localparam logic [KEY_W-1:0] KEY_8 = 5'h08;
    localparam logic [KEY_W-1:0] KEY_9 = 5'h09;
    localparam logic [KEY_W-1:0] KEY_A = 5'h0A;
    localparam logic [KEY_W-1:0] KEY_B = 5'h0B;
    localparam logic [KEY_W-1:0] KEY_C = 5'h0C;
    localparam logic [KEY_W-1:0] KEY_D = 5'h0D;
    localparam logic [KEY_W-1:0] KEY_E = 5'h0E;
    localparam logic [KEY_W-1:0] KEY_F = 5'h0F;

    // key_event FSM encoding; the numeric values are exported on state_dbg.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_t;

    // A scanner sample counts only when a key is down and the code is real.
    function automatic logic key_valid(input logic pressed, input logic [KEY_W-1:0] key);
        return pressed & ~key[KEY_W-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_repeat_timer.sv
`default_nettype none
// ============================================================================
//  Module      : key_repeat_timer
//  Description : Hold-time counter for auto-repeat. Counts cycles in which the
//                held key is still present (run=1), saturating at all-ones,
//                and flags the cycles that must produce a repeat strobe:
//                first when the count reaches REPEAT_DELAY, then every
//                REPEAT_RATE counted cycles after that.
//  Ports       : clk   - system clock
//                rst   - synchronous reset, active-high
//                clear - restart the hold time (new press accepted)
//                run   - held key present this cycle; advances the count
//                fire  - combinational: this run cycle is a repeat point
//  Revision    : 1.0 - initial release
// ============================================================================
module key_repeat_timer
    import key_pkg::*;
#(
    parameter int CNT_W        = 20,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic fire
);

    // Comparisons are done at 33 bits so a REPEAT_DELAY larger than the
    // counter range simply never matches instead of aliasing after truncation.
    localparam logic             c_enabled   = (REPEAT_RATE != 0);
    localparam logic [32:0]      c_delay     = 33'(REPEAT_DELAY);
    localparam logic [32:0]      c_rate_last = c_enabled ? 33'(REPEAT_RATE - 1) : 33'd0;
    localparam logic [CNT_W-1:0] c_one       = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_rep;     // held-cycle count, frozen while run=0
    logic [CNT_W-1:0] r_phase;   // position inside the current repeat period
    logic             r_past;    // first repeat point already reached

    logic             w_rep_sat;
    logic [CNT_W-1:0] w_rep_next;
    logic             w_hit_delay;
    logic             w_phase_wrap;

    assign w_rep_sat    = &r_rep;
    assign w_rep_next   = w_rep_sat ? r_rep : (r_rep + c_one);

    // The count reaches REPEAT_DELAY on this cycle (only once per press).
    assign w_hit_delay  = !r_past && !w_rep_sat && (33'(w_rep_next) == c_delay);

    // After the first repeat, a period counter keeps strobing at a steady
    // rate even once r_rep has saturated.
    assign w_phase_wrap = r_past && (33'(r_phase) == c_rate_last);

    assign fire = c_enabled && run && (w_hit_delay || w_phase_wrap);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_rep   <= '0;
            r_phase <= '0;
            r_past  <= 1'b0;
        end else if (run) begin
            r_rep <= w_rep_next;
            if (w_hit_delay) begin
                r_past  <= 1'b1;
                r_phase <= '0;
            end else if (r_past) begin
                r_phase <= w_phase_wrap ? '0 : (r_phase + c_one);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_event.sv
`default_nettype none
// ============================================================================
//  Module      : key_event
//  Description : Turns the keypad scanner's raw (bouncing) key code and
//                pressed flag into clean single-cycle events for the game
//                FSM: press, auto-repeat and release. Same clock domain as
//                the scanner, so inputs are used directly.
//  Ports       : clk            - system clock
//                rst            - synchronous reset, active-high
//                key_in[4:0]    - raw key code, [4]=1 means no/invalid key
//                pressed_in     - raw "a key is down" flag
//                key_out[4:0]   - debounced key, updated only on a new press
//                key_strobe     - 1-cycle pulse on press and each repeat
//                key_held       - high while a debounced key is down
//                release_strobe - 1-cycle pulse on accepted release
//                state_dbg[1:0] - current FSM state
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event
    import key_pkg::*;
#(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             pressed_in,
    output logic [KEY_W-1:0] key_out,
    output logic             key_strobe,
    output logic             key_held,
    output logic             release_strobe,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [KEY_W-1:0] r_cand;    // key being debounced towards a press
    logic [CNT_W-1:0] r_cnt;     // debounce count for press and release

    logic w_valid;
    logic w_match_cand;
    logic w_match_key;
    logic w_db_done;
    logic w_rep_clear;
    logic w_rep_run;
    logic w_rep_fire;

    assign w_valid      = key_valid(pressed_in, key_in);
    assign w_match_cand = w_valid && (key_in == r_cand);
    assign w_match_key  = w_valid && (key_in == key_out);
    assign w_db_done    = (r_cnt == c_db_last);

    // Hold time restarts on each accepted press and only advances while the
    // debounced key is seen in HELD, so a release bounce freezes it.
    assign w_rep_clear  = (r_state == ST_DB_PRESS) && w_match_cand && w_db_done;
    assign w_rep_run    = (r_state == ST_HELD) && w_match_key;

    key_repeat_timer #(
        .CNT_W        (CNT_W),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_repeat (
        .clk   (clk),
        .rst   (rst),
        .clear (w_rep_clear),
        .run   (w_rep_run),
        .fire  (w_rep_fire)
    );

    assign state_dbg = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cand         <= '0;
            r_cnt          <= '0;
            key_out        <= '0;
            key_strobe     <= 1'b0;
            key_held       <= 1'b0;
            release_strobe <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            key_strobe     <= 1'b0;
            release_strobe <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_cand  <= key_in;
                        r_cnt   <= '0;
                        r_state <= ST_DB_PRESS;
                    end
                end

                ST_DB_PRESS: begin
                    if (!w_match_cand) begin
                        // Bounce or key change: drop the attempt silently.
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_db_done) begin
                        key_out    <= r_cand;
                        key_strobe <= 1'b1;
                        key_held   <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ST_HELD;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end

                ST_HELD: begin
                    if (w_match_key) begin
                        key_strobe <= w_rep_fire;
                    end else begin
                        // Released or rolled over to another key.
                        r_cnt   <= '0;
                        r_state <= ST_DB_RELEASE;
                    end
                end

                ST_DB_RELEASE: begin
                    if (w_match_key) begin
                        // Release bounce: back to HELD with no event.
                        r_cnt   <= '0;
                        r_state <= ST_HELD;
                    end else if (w_db_done) begin
                        key_held       <= 1'b0;
                        release_strobe <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event
//  Description : Self-checking bench for key_event with directed scenarios
//                and random scanner traffic, compared every cycle against a
//                sample-history reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event;
    import key_pkg::*;

    localparam int DB   = 4;
    localparam int DLY  = 10;
    localparam int RATE = 3;
    localparam int CW   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [KEY_W-1:0] key_in;
    logic             pressed_in;
    logic [KEY_W-1:0] key_out;
    logic             key_strobe;
    logic             key_held;
    logic             release_strobe;
    logic [1:0]       state_dbg;

    always #5 clk = ~clk;

    key_event #(
        .CNT_W           (CW),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_RATE     (RATE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .pressed_in     (pressed_in),
        .key_out        (key_out),
        .key_strobe     (key_strobe),
        .key_held       (key_held),
        .release_strobe (release_strobe),
        .state_dbg      (state_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: tracks run lengths of identical valid samples and
    // the hold time of the accepted key.
    bit         m_down;      // a debounced key is down
    bit         m_rel;       // down, but currently seeing release samples
    int         m_run;       // length of the current press candidate run
    int         m_relrun;    // release samples counted after the first one
    int         m_t;         // samples the accepted key has been held
    logic [4:0] m_cand;
    logic [4:0] m_key;
    bit         m_held, m_ks, m_rs;

    function automatic int m_state();
        if (!m_down) return (m_run > 0) ? 1 : 0;
        return m_rel ? 3 : 2;
    endfunction

    task automatic model_update(input logic rr, input logic [4:0] kk, input logic pp);
        bit v;
        v    = pp && !kk[4];
        m_ks = 0;
        m_rs = 0;
        if (rr) begin
            m_down = 0; m_rel = 0; m_run = 0; m_relrun = 0; m_t = 0;
            m_cand = '0; m_key = '0; m_held = 0;
        end else if (!m_down) begin
            if (m_run == 0) begin
                if (v) begin m_cand = kk; m_run = 1; end
            end else if (v && kk == m_cand) begin
                if (m_run == DB) begin
                    m_key = m_cand; m_ks = 1; m_held = 1; m_down = 1;
                    m_rel = 0; m_t = 0; m_run = 0;
                end else begin
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
        end else if (!m_rel) begin
            if (v && kk == m_key) begin
                m_t++;
                if (RATE != 0 && m_t >= DLY && ((m_t - DLY) % RATE) == 0) m_ks = 1;
            end else begin
                m_rel = 1; m_relrun = 0;
            end
        end else begin
            if (v && kk == m_key) m_rel = 0;
            else if (m_relrun == DB - 1) begin
                m_rs = 1; m_held = 0; m_down = 0; m_rel = 0;
            end else m_relrun++;
        end
    endtask

    // Per-window event statistics for the directed scenarios.
    int cyc_idx, ks_count, rs_count, first_ks;

    task automatic begin_window();
        cyc_idx = 0; ks_count = 0; rs_count = 0; first_ks = -1;
    endtask

    task automatic step(input logic r, input logic [4:0] k, input logic p);
        rst = r; key_in = k; pressed_in = p;
        @(posedge clk);
        model_update(r, k, p);
        #1;
        check("key_strobe",     32'(key_strobe),     32'(m_ks));
        check("release_strobe", 32'(release_strobe), 32'(m_rs));
        check("key_held",       32'(key_held),       32'(m_held));
        check("key_out",        32'(key_out),        32'(m_key));
        check("state_dbg",      32'(state_dbg),      32'(m_state()));
        check("strobe_overlap", 32'(key_strobe & release_strobe), 32'd0);
        if (key_strobe) begin
            ks_count++;
            if (first_ks < 0) first_ks = cyc_idx;
        end
        if (release_strobe) rs_count++;
        cyc_idx++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, KEY_NONE, 1'b0);
    endtask

    task automatic hold(input logic [4:0] k, input int n);
        for (int i = 0; i < n; i++) step(1'b0, k, 1'b1);
    endtask

    initial begin
        rst = 1'b1; key_in = KEY_NONE; pressed_in = 1'b0;
        step(1'b1, KEY_NONE, 1'b0);
        step(1'b1, KEY_NONE, 1'b0);

        // Clean press: strobe 5 cycles after the first sample.
        begin_window();
        hold(KEY_5, 20);
        check("t1_latency", 32'(first_ks + 1), 32'd5);
        check("t1_key_out", 32'(key_out), 32'h05);
        idle_cycles(12);

        // Press bounce 1,0,1,0 then steady.
        step(1'b0, KEY_A, 1'b1);
        step(1'b0, KEY_A, 1'b0);
        step(1'b0, KEY_A, 1'b1);
        step(1'b0, KEY_A, 1'b0);
        begin_window();
        hold(KEY_A, 12);
        check("t2_latency", 32'(first_ks + 1), 32'd5);
        check("t2_one_strobe", 32'(ks_count), 32'd1);
        idle_cycles(12);

        // Auto-repeat: press + repeats at hold 10,13,16,19,22,25.
        begin_window();
        hold(KEY_3, 30);
        check("t3_strobes", 32'(ks_count), 32'd7);
        check("t3_key_out", 32'(key_out), 32'h03);

        // Release with a 2-cycle glitch back to the held key.
        begin_window();
        step(1'b0, KEY_NONE, 1'b0);
        hold(KEY_3, 2);
        idle_cycles(10);
        check("t4_no_press", 32'(ks_count), 32'd0);
        check("t4_one_release", 32'(rs_count), 32'd1);
        check("t4_held_low", 32'(key_held), 32'd0);

        // Rollover 1 -> 2.
        begin_window();
        hold(KEY_1, 8);
        hold(KEY_2, 15);
        check("t5_release", 32'(rs_count), 32'd1);
        check("t5_presses", 32'(ks_count), 32'd2);
        check("t5_key_out", 32'(key_out), 32'h02);
        idle_cycles(12);

        // Reset during press debounce (cnt=2).
        begin_window();
        hold(KEY_5, 3);
        step(1'b1, KEY_5, 1'b1);
        check("t6_state", 32'(state_dbg), 32'd0);
        check("t6_key_out", 32'(key_out), 32'd0);
        idle_cycles(8);
        check("t6_no_strobe", 32'(ks_count), 32'd0);

        // Random scanner traffic.
        for (int b = 0; b < 300; b++) begin
            logic [4:0] k;
            logic       p, r;
            int         len;
            if ($urandom_range(0, 3) == 0) k = {1'b1, 4'($urandom_range(0, 15))};
            else                           k = {1'b0, 4'($urandom_range(0, 2))};
            p   = ($urandom_range(0, 5) != 0);
            r   = ($urandom_range(0, 80) == 0);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 35) : $urandom_range(1, 7);
            for (int i = 0; i < len; i++) step(r, k, p);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
